// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;
`include "serial_adder_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `SA_ST_IDLE,
    ST_RUN  = `SA_ST_RUN,
    ST_DONE = `SA_ST_DONE
  } state_t;

  // Bit counter width: ceil(log2(w+1)), never below one bit.
  function automatic int cnt_bits(input int w);
    int b;
    b = $clog2(w + 1);
    return (b < 1) ? 1 : b;
  endfunction
endpackage

// File: rtl/serial_adder_defs.vh
// State encodings for the serial adder FSM, shared by the RTL package and anything
// that decodes the debug state.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define SA_ST_IDLE 2'b00
`define SA_ST_RUN  2'b01
`define SA_ST_DONE 2'b10
`endif

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell; the only arithmetic on the operand datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Handshake: start is accepted on an edge when busy=0 (IDLE or DONE); done is a
// one-cycle pulse during which sum/cout hold the new result; start is ignored while busy=1.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           dbg_state
);
  localparam int CW = cnt_bits(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, shreg, shreg_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last;

  // Operands shift right so the cell always sees bit 0; no indexed select needed.
  full_adder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign last      = (cnt == CW'(WIDTH - 1));
  assign dbg_state = state;

  always_comb begin
    shreg_nx            = shreg >> 1;
    shreg_nx[WIDTH-1]   = fa_sum;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = start ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      shreg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= fa_cout;
          shreg <= shreg_nx;
          cnt   <= cnt + CW'(1);
          // Result registers move only on the completing edge.
          if (last) begin
            sum  <= shreg_nx;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  state_t     st8;

  // WIDTH=1 instance
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  state_t     st1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state(st8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .dbg_state(st1)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];
  logic [8:0] prev8 = '0;
  int         pulses8 = 0;

  always @(negedge clk) if (done8) pulses8++;

  task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic c);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    exp_q8.push_back({1'b0, x} + {1'b0, y} + 9'(c));
  endtask

  // Runs from the accepting edge up to the done sample. start stays high for 'hold'
  // samples; at sample 'disturb' a one-cycle start with fresh operands is injected.
  task automatic wait_result8(input int hold, input int disturb, input bit chk_busy);
    int n, bc;
    logic [8:0] e;
    n = 0; bc = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done8) break;
      bc += int'(busy8);
      n_checks++;
      if ({cout8, sum8} !== prev8) begin
        n_fail++;
        $display("FAIL hold_during_run: got %h required %h (n=%0d)", {cout8, sum8}, prev8, n);
      end
      if (n == disturb) begin
        start8 = 1'b1; a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1));
      end else if (n >= hold) begin
        start8 = 1'b0; a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1));
      end
    end
    n_checks++;
    if (!done8) begin
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles required %0d", n, 9);
    end else begin
      if (n != 9) begin
        n_fail++;
        $display("FAIL latency: got %0d required 9", n);
      end
      n_checks++;
      if (st8 !== ST_DONE) begin
        n_fail++;
        $display("FAIL state_done: got %b required %b", st8, ST_DONE);
      end
      if (chk_busy) begin
        n_checks++;
        if (bc != 8) begin
          n_fail++;
          $display("FAIL busy_cycles: got %0d required 8", bc);
        end
      end
      n_checks++;
      if (exp_q8.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got done with empty queue required an entry");
      end else begin
        e = exp_q8.pop_front();
        if ({cout8, sum8} !== e) begin
          n_fail++;
          $display("FAIL result8: got cout=%b sum=%h required cout=%b sum=%h",
                   cout8, sum8, e[8], e[7:0]);
        end
        prev8 = e;
      end
    end
  endtask

  task automatic test_reset;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; start1 = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0 || st8 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state8: got busy=%b done=%b cout=%b sum=%h st=%b required all 0",
               busy8, done8, cout8, sum8, st8);
    end
    n_checks++;
    if ({busy1, done1, cout1, sum1} !== 4'd0 || st1 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state1: got busy=%b done=%b cout=%b sum=%b st=%b required all 0",
               busy1, done1, cout1, sum1, st1);
    end
    start1 = 1'b0;
  endtask

  // First edge with rst=0 accepts the start; all-zero operands.
  task automatic test_zero;
    rst = 1'b0;
    launch8(8'h00, 8'h00, 1'b0);
    wait_result8(1, 0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || st8 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%b st=%b required done=0 st=%b", done8, st8, ST_IDLE);
    end
  endtask

  task automatic test_vectors;
    logic [16:0] vec[3];
    vec[0] = {8'hFF, 8'h01, 1'b0};
    vec[1] = {8'hA5, 8'h5A, 1'b1};
    vec[2] = {8'h3C, 8'h42, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      launch8(vec[i][16:9], vec[i][8:1], vec[i][0]);
      wait_result8(1, 0, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      launch8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_result8(1, 0, 1'b0);
    end
  endtask

  task automatic test_ignore_start;
    int p0;
    @(negedge clk);
    p0 = pulses8;
    launch8(8'h12, 8'h34, 1'b1);
    wait_result8(1, 3, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (pulses8 - p0 != 1) begin
      n_fail++;
      $display("FAIL single_done: got %0d pulses required 1", pulses8 - p0);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    launch8(8'h01, 8'h02, 1'b0);
    wait_result8(1, 0, 1'b0);
    launch8(8'h10, 8'h20, 1'b0);
    wait_result8(3, 0, 1'b0);
  endtask

  task automatic test_reset_abort;
    int p0;
    @(negedge clk);
    p0 = pulses8;
    launch8(8'h77, 8'h11, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q8.pop_back());
    prev8 = '0;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0 || st8 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b done=%b cout=%b sum=%h required all 0",
               busy8, done8, cout8, sum8);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (pulses8 != p0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses required 0", pulses8 - p0);
    end
  endtask

  task automatic test_width1;
    logic [2:0] v;
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      exp_q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      n_checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL w1_busy: got busy=%b done=%b required busy=1 done=0 (i=%0d)", busy1, done1, i);
      end
      @(negedge clk);
      e = exp_q1.pop_front();
      n_checks++;
      if (done1 !== 1'b1 || {cout1, sum1} !== e) begin
        n_fail++;
        $display("FAIL w1_result: got done=%b {cout,sum}=%b required done=1 %b (i=%0d)",
                 done1, {cout1, sum1}, e, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_width1();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse; sum/cout valid while high.
REQ-010 sum  output  WIDTH  result register, (a+b+cin) mod 2^WIDTH.
REQ-011 cout  output  1  carry-out of the WIDTH-bit addition.

Function
REQ-012 The adder SHALL process one bit per cycle, LSB first, through a single 1-bit full-adder cell and a registered carry.
REQ-013 States: IDLE, RUN, DONE. Encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
REQ-014 IDLE or DONE with start=1 at an edge: latch a, b, cin; clear the bit counter; next state RUN.
REQ-015 DONE with start=0 at an edge: next state IDLE.
REQ-016 RUN: each edge computes bit[cnt] with the carry register, writes the bit into a shift register, updates the carry, and increments cnt.
REQ-017 RUN with cnt=WIDTH-1: the edge completes the last bit, transfers the result to sum and the final carry to cout, and enters DONE.
REQ-018 Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH, for exactly one cycle.
REQ-019 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-020 start is ignored while busy=1; the operands in flight are unaffected.
REQ-021 Back-to-back: start=1 during DONE is accepted, so done pulses are spaced exactly WIDTH+1 cycles apart.
REQ-022 sum and cout change only at the completing edge of REQ-017; they hold their values through IDLE and through the next RUN.
REQ-023 Input changes on a, b and cin outside an accepting edge have no effect.
REQ-024 The counter is ceil(log2(WIDTH+1)) bits wide, with a minimum of 1 bit; WIDTH=1 completes in a single RUN cycle.

Reset
REQ-025 rst=1 at an edge forces state IDLE, busy=0, done=0, sum=0, cout=0, carry=0 and cnt=0, overriding start.
REQ-026 Reset during RUN aborts the operation; no done pulse follows and sum keeps the reset value 0.
REQ-027 The first start is accepted at the first edge with rst=0.

Structure
REQ-028 State encodings (REQ-013) reside in the shared include serial_adder_defs.vh, reused by the bench.
REQ-029 The 1-bit cell is the sub-module full_adder (ports a, b, cin, sum, cout) and is instantiated exactly once.
REQ-030 No arithmetic wider than 1 bit is permitted on the operand datapath; only the counter uses multi-bit increment.

Verification (WIDTH=8 unless noted)
REQ-031 a=8'h00, b=8'h00, cin=0, start one cycle -> done after edge k+8, sum=8'h00, cout=0; busy high for exactly 8 cycles.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0.
REQ-033 start=1 with new operands 3 cycles into RUN -> ignored; the result matches the original operands; exactly one done pulse.
REQ-034 start held high across DONE with new operands (8'h10+8'h20) -> second done 9 cycles after the first, sum=8'h30.
REQ-035 rst=1 at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse for the aborted operation.
REQ-036 WIDTH=1: all 8 combinations of a, b, cin -> done one cycle after the RUN edge; {cout,sum} equals a+b+cin.
